// File: rtl/mult_pipe_param.sv
// Pipelined signed/unsigned WIDTH x WIDTH multiplier with an optional multiply-accumulate
// in the final stage. Latency is exactly STAGES cycles. A stall freezes the whole pipe.

module mult_pipe_param #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3,
  parameter int ACC_EN = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_multa_ns,
  input  logic               i_multb_ns,
  input  logic [WIDTH-1:0]   i_multa,
  input  logic [WIDTH-1:0]   i_multb,
  input  logic               i_mac,
  input  logic               i_acc_clr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int PW      = 2 * WIDTH;
  localparam bit HAS_ACC = (ACC_EN != 0);

  // Handshake: a beat is taken when i_valid && o_ready, a result leaves when
  // o_valid && i_ready. The only stall source is an unaccepted result, so every
  // stage (bubbles included) advances together on adv and holds together otherwise.
  logic adv;
  assign adv     = !(o_valid && !i_ready);
  assign o_ready = adv;

  // Sign/zero extension to 2*WIDTH gives the exact product modulo 2^(2*WIDTH).
  logic          sign_a, sign_b;
  logic [PW-1:0] a_ext, b_ext, in_prod;
  logic          in_mac, in_clr;

  assign sign_a  = i_multa_ns & i_multa[WIDTH-1];
  assign sign_b  = i_multb_ns & i_multb[WIDTH-1];
  assign a_ext   = {{WIDTH{sign_a}}, i_multa};
  assign b_ext   = {{WIDTH{sign_b}}, i_multb};
  assign in_prod = a_ext * b_ext;
  assign in_mac  = HAS_ACC & i_mac;
  assign in_clr  = HAS_ACC & i_mac & i_acc_clr;

  // Beat presented to the final (output/accumulate) stage.
  logic          fin_v, fin_mac, fin_clr;
  logic [PW-1:0] fin_prod;

  generate
    if (STAGES == 1) begin : g_direct
      assign fin_v    = i_valid;
      assign fin_mac  = in_mac;
      assign fin_clr  = in_clr;
      assign fin_prod = in_prod;
    end else begin : g_pipe
      logic [STAGES-2:0] sv, sm, sc;
      logic [PW-1:0]     sp [STAGES-1];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          sv <= '0;
          sm <= '0;
          sc <= '0;
          for (int k = 0; k < STAGES - 1; k++) sp[k] <= '0;
        end else if (adv) begin
          sv[0] <= i_valid;
          sm[0] <= in_mac;
          sc[0] <= in_clr;
          sp[0] <= in_prod;
          for (int k = 1; k < STAGES - 1; k++) begin
            sv[k] <= sv[k-1];
            sm[k] <= sm[k-1];
            sc[k] <= sc[k-1];
            sp[k] <= sp[k-1];
          end
        end
      end

      assign fin_v    = sv[STAGES-2];
      assign fin_mac  = sm[STAGES-2];
      assign fin_clr  = sc[STAGES-2];
      assign fin_prod = sp[STAGES-2];
    end
  endgenerate

  logic [PW-1:0] acc, acc_sum;
  assign acc_sum = (fin_clr ? '0 : acc) + fin_prod;

  generate
    if (HAS_ACC) begin : g_acc
      logic [PW-1:0] acc_q;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                         acc_q <= '0;
        else if (adv && fin_v && fin_mac)  acc_q <= acc_sum;
      end
      assign acc = acc_q;
    end else begin : g_no_acc
      assign acc = '0;
    end
  endgenerate

  // Output register holds its value across bubbles; only valid beats load it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_product <= '0;
    end else if (adv) begin
      o_valid <= fin_v;
      if (fin_v) o_product <= fin_mac ? acc_sum : fin_prod;
    end
  end

endmodule

// File: tb/tb_mult_pipe_param.sv
// Bench for mult_pipe_param: 64-bit/3-stage MAC instance plus two 8-bit instances
// (1 and 8 stages) for latency and narrow-width arithmetic.

module tb_mult_pipe_param;

  localparam int W  = 64;
  localparam int PW = 2 * W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- main DUT ----------------
  logic          valid, dut_ready, sa, sb, mac, clr, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [PW-1:0] prod;

  mult_pipe_param #(.WIDTH(W), .STAGES(3), .ACC_EN(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(dut_ready),
    .i_multa_ns(sa), .i_multb_ns(sb), .i_multa(a), .i_multb(b),
    .i_mac(mac), .i_acc_clr(clr), .o_valid(out_valid), .i_ready(out_ready),
    .o_product(prod)
  );

  // ---------------- 8-bit sweep DUTs ----------------
  logic        valid8, sa8, sb8, rdy8_1, rdy8_8, ov1, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] p1, p8;

  mult_pipe_param #(.WIDTH(8), .STAGES(1), .ACC_EN(1)) dut8_s1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid8), .o_ready(rdy8_1),
    .i_multa_ns(sa8), .i_multb_ns(sb8), .i_multa(a8), .i_multb(b8),
    .i_mac(1'b0), .i_acc_clr(1'b0), .o_valid(ov1), .i_ready(1'b1),
    .o_product(p1)
  );

  mult_pipe_param #(.WIDTH(8), .STAGES(8), .ACC_EN(0)) dut8_s8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid8), .o_ready(rdy8_8),
    .i_multa_ns(sa8), .i_multb_ns(sb8), .i_multa(a8), .i_multb(b8),
    .i_mac(1'b0), .i_acc_clr(1'b0), .o_valid(ov8), .i_ready(1'b1),
    .o_product(p8)
  );

  // ---------------- scoreboard ----------------
  int            checks = 0;
  int            errors = 0;
  int            received = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_v;
  logic [PW-1:0] hold_prod;
  bit            hold_flag = 0;
  logic [PW-1:0] acc_m;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic msa, input logic msb);
    logic signed [PW+1:0] ea, eb, pr;
    ea = $signed({{(W+2){msa & ma[W-1]}}, ma});
    eb = $signed({{(W+2){msb & mb[W-1]}}, mb});
    pr = ea * eb;
    return pr[PW-1:0];
  endfunction

  // Monitor: pops on every transfer, checks stall stability and o_ready during stalls.
  always @(negedge clk) begin
    if (rst) begin
      hold_flag = 0;
    end else begin
      if (hold_flag) begin
        chk("stall_hold_product", prod, hold_prod);
        chk("stall_hold_valid", {127'b0, out_valid}, 1);
      end
      hold_flag = 0;
      if (out_valid && !out_ready) begin
        chk("stall_o_ready", {127'b0, dut_ready}, 0);
        hold_flag = 1;
        hold_prod = prod;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", prod);
        end else begin
          exp_v = exp_q.pop_front();
          chk("result", prod, exp_v);
          received++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsa,
                      input logic tsb, input logic tm, input logic tc, input logic [PW-1:0] te);
    bit rdy;
    valid = 1'b1; a = ta; b = tb_; sa = tsa; sb = tsb; mac = tm; clr = tc;
    rdy = 0;
    for (int t = 0; t < 100 && !rdy; t++) begin
      @(negedge clk);
      rdy = dut_ready;
      @(posedge clk);
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got o_ready=0 for 100 cycles expected acceptance");
    end else begin
      exp_q.push_back(te);
    end
    #1 valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", PW'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic w8(input logic [7:0] ta, input logic [7:0] tb_, input logic tsa,
                    input logic tsb, input logic [15:0] te);
    int la, lb;
    logic [15:0] pa, pb;
    valid8 = 1'b1; a8 = ta; b8 = tb_; sa8 = tsa; sb8 = tsb;
    @(posedge clk);
    #1 valid8 = 1'b0;
    la = 0; lb = 0; pa = '0; pb = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ov1 && la == 0) begin la = c; pa = p1; end
      if (ov8 && lb == 0) begin lb = c; pb = p8; end
    end
    chk("w8_latency_s1", PW'(la), 1);
    chk("w8_latency_s8", PW'(lb), 8);
    chk("w8_product_s1", {112'b0, pa}, {112'b0, te});
    chk("w8_product_s8", {112'b0, pb}, {112'b0, te});
    @(posedge clk);
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0]  va, vb;
    logic          vsa, vsb, vmac, vclr;
    logic [PW-1:0] vexp;
  } vec_t;

  vec_t vecs[15];
  logic streaming;
  int   lat, r0;

  initial begin
    vecs[0]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 0, 0, 0, 0, 128'hFFFFFFFFFFFFFFFE_0000000000000001};
    vecs[1]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 0, 128'hFFFFFFFFFFFFFFFF_0000000000000001};
    vecs[2]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0, 0, 128'h1};
    vecs[3]  = '{64'h8000000000000000, 64'h8000000000000000, 1, 1, 0, 0, 128'h40000000000000000000000000000000};
    vecs[4]  = '{64'd3, 64'd4, 0, 0, 1, 1, 128'd12};
    vecs[5]  = '{64'd5, 64'd6, 0, 0, 1, 0, 128'd42};
    vecs[6]  = '{64'd2, 64'd2, 0, 0, 0, 0, 128'd4};
    vecs[7]  = '{64'd1, 64'd1, 0, 0, 1, 0, 128'd43};
    vecs[8]  = '{64'd4, 64'd5, 0, 0, 0, 1, 128'd20};
    vecs[9]  = '{64'd1, 64'd1, 0, 0, 1, 0, 128'd44};
    vecs[10] = '{64'h8000000000000000, 64'd2, 0, 0, 0, 0, 128'h1_0000000000000000};
    vecs[11] = '{64'hFFFFFFFFFFFFFFFE, 64'd3, 1, 0, 0, 0, 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFA};
    vecs[12] = '{64'd0, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0, 0, 128'd0};
    vecs[13] = '{64'h7FFFFFFFFFFFFFFF, 64'h8000000000000000, 1, 1, 0, 0, 128'hC0000000000000008000000000000000};
    vecs[14] = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 0, 1, 0, 0, 128'hFFFFFFFFFFFFFFFF_8000000000000000};

    rst = 1'b1; valid = 0; a = '0; b = '0; sa = 0; sb = 0; mac = 0; clr = 0; out_ready = 1'b1;
    valid8 = 0; a8 = '0; b8 = '0; sa8 = 0; sb8 = 0; streaming = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_o_valid", {127'b0, out_valid}, 0);
    chk("reset_o_product", prod, 0);
    chk("reset_o_ready", {127'b0, dut_ready}, 1);
    chk("reset_w8_valid", {126'b0, ov1, ov8}, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Latency of a single beat with i_ready held high
    send(vecs[0].va, vecs[0].vb, 0, 0, 0, 0, vecs[0].vexp);
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (out_valid && lat == 0) lat = c;
    end
    chk("latency_s3", PW'(lat), 3);
    drain();

    // Table, streamed back-to-back (includes MAC chain 12, 42, 4, 43)
    for (int i = 0; i < 15; i++)
      send(vecs[i].va, vecs[i].vb, vecs[i].vsa, vecs[i].vsb, vecs[i].vmac, vecs[i].vclr, vecs[i].vexp);
    drain();

    // Backpressure: 5 beats, i_ready low for 4 cycles while results are pending
    r0 = received;
    fork
      begin
        for (int k = 0; k < 5; k++)
          send(64'(k + 2), 64'(k + 7), 0, 0, 0, 0, 128'((k + 2) * (k + 7)));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", PW'(received - r0), 5);

    // Random stream with random backpressure and MAC chaining
    streaming = 1;
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          logic [W-1:0]  ra, rb;
          logic          rsa, rsb, rm, rc;
          logic [PW-1:0] p;
          ra  = ($urandom_range(0, 4) == 0) ? '1 : {$urandom, $urandom};
          rb  = ($urandom_range(0, 4) == 0) ? {1'b1, 63'b0} : {$urandom, $urandom};
          rsa = 1'($urandom_range(0, 1));
          rsb = 1'($urandom_range(0, 1));
          rm  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
          rc  = (k == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
          p   = model(ra, rb, rsa, rsb);
          if (rm) begin
            acc_m = (rc ? '0 : acc_m) + p;
            p = acc_m;
          end
          send(ra, rb, rsa, rsb, rm, rc, p);
        end
        streaming = 0;
      end
      begin
        while (streaming) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two beats in flight and one result waiting
    send(64'd10, 64'd10, 0, 0, 1, 1, 128'd100);
    send(64'd7, 64'd7, 0, 0, 0, 0, 128'd49);
    send(64'd8, 64'd8, 0, 0, 0, 0, 128'd64);
    chk("pre_reset_valid", {127'b0, out_valid}, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_valid", {127'b0, out_valid}, 0);
    chk("async_reset_product", prod, 0);
    chk("async_reset_ready", {127'b0, dut_ready}, 1);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    r0 = received;
    repeat (10) @(posedge clk);
    #1;
    chk("no_stale_results", PW'(received - r0), 0);
    send(64'd3, 64'd3, 0, 0, 1, 0, 128'd9);
    drain();

    // Narrow width, 1 and 8 stages
    w8(8'h80, 8'h80, 1, 1, 16'h4000);
    w8(8'hFF, 8'hFF, 0, 0, 16'hFE01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
